move_ctrl: RTL and testbench

//  Turn and move controller for the tic-tac-toe VGA game. Sits upstream of the board/render

---
 rtl/move_ctrl_if.sv | 24 ++
 rtl/move_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_move_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_ctrl_if.sv
// Signal bundle between the tic-tac-toe move controller and its neighbours:
// raw player inputs in, board/turn/result state out to the renderer.
`timescale 1ns/1ps
interface move_ctrl_if;
    logic        button;
    logic [8:0]  switches;
    logic [17:0] board;
    logic        turn;
    logic [8:0]  change;
    logic        illegal;
    logic [1:0]  winner;
    logic [7:0]  win_line;
    logic        game_over;

    modport master (
        output button, switches,
        input  board, turn, change, illegal, winner, win_line, game_over
    );

    modport slave (
        input  button, switches,
        output board, turn, change, illegal, winner, win_line, game_over
    );
endinterface

// File: rtl/move_ctrl.sv
// Turn and move controller for the tic-tac-toe VGA game: synchronises and
// debounces the player inputs, owns the board and detects wins and draws.
`timescale 1ns/1ps
module move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    move_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_EVAL = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Three cell indices per line: rows, then columns, then both diagonals.
    localparam int LINE_TBL [0:23] = '{0, 1, 2,  3, 4, 5,  6, 7, 8,
                                       0, 3, 6,  1, 4, 7,  2, 5, 8,
                                       0, 4, 8,  2, 4, 6};

    function automatic logic [17:0] sel_mask(input logic [8:0] sel);
        logic [17:0] m;
        m = 18'h00000;
        for (int i = 0; i < 9; i++) begin
            m[2*i +: 2] = {sel[i], sel[i]};
        end
        return m;
    endfunction

    function automatic logic line_won(input logic [17:0] b, input int line);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        c0 = b[2*LINE_TBL[3*line]     +: 2];
        c1 = b[2*LINE_TBL[3*line + 1] +: 2];
        c2 = b[2*LINE_TBL[3*line + 2] +: 2];
        return (c0 != 2'b00) && (c0 == c1) && (c0 == c2);
    endfunction

    logic             btn_meta_q, btn_sync_q;
    logic [8:0]       sw_meta_q, sw_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic             press_q;

    state_e           state_q, state_d;
    logic [17:0]      board_q, board_d;
    logic             turn_q, turn_d;
    logic [8:0]       change_q, change_d;
    logic             illegal_q, illegal_d;
    logic [1:0]       winner_q, winner_d;
    logic [7:0]       win_line_q, win_line_d;
    logic             game_over_q, game_over_d;

    logic             sel_valid_s;
    logic [17:0]      sel_mask_s;
    logic             occupied_s;
    logic [1:0]       mark_s;
    logic [7:0]       win_line_s;
    logic [1:0]       win_mark_s;
    logic             board_full_s;

    // Two-flop synchronisers for the asynchronous button and switches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            sw_meta_q  <= 9'h000;
            sw_sync_q  <= 9'h000;
        end else begin
            btn_meta_q <= bus.button;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.switches;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (btn_sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = btn_sync_q;
                cnt_d    = {CNT_W{1'b0}};
            end else begin
                cnt_d    = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Debounce state; the press pulse is registered off the accepted 0->1 edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q         <= {CNT_W{1'b0}};
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
        end
    end

    // Exactly one switch up means a valid selection.
    assign sel_valid_s = (sw_sync_q != 9'h000) && ((sw_sync_q & (sw_sync_q - 9'h001)) == 9'h000);
    assign sel_mask_s  = sel_mask(sw_sync_q);
    assign occupied_s  = |(board_q & sel_mask_s);
    assign mark_s      = turn_q ? 2'b10 : 2'b01;

    // Line and full-board detection on the current board.
    always_comb begin
        win_line_s   = 8'h00;
        win_mark_s   = 2'b00;
        board_full_s = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (line_won(board_q, l)) begin
                win_line_s[l] = 1'b1;
                win_mark_s    = board_q[2*LINE_TBL[3*l] +: 2];
            end else begin
                win_line_s[l] = 1'b0;
            end
        end
        for (int c = 0; c < 9; c++) begin
            board_full_s = board_full_s & (board_q[2*c +: 2] != 2'b00);
        end
    end

    // Game FSM next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        turn_d      = turn_q;
        change_d    = 9'h000;
        illegal_d   = 1'b0;
        winner_d    = winner_q;
        win_line_d  = win_line_q;
        game_over_d = game_over_q;
        case (state_q)
            ST_PLAY: begin
                if (press_q) begin
                    if (sel_valid_s && !occupied_s) begin
                        board_d  = board_q | (sel_mask_s & {9{mark_s}});
                        change_d = sw_sync_q;
                        turn_d   = ~turn_q;
                        state_d  = ST_EVAL;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_EVAL: begin
                // A win is checked first so a last-cell win never reads as a draw.
                if (win_line_s != 8'h00) begin
                    winner_d    = win_mark_s;
                    win_line_d  = win_line_s;
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else if (board_full_s) begin
                    winner_d    = 2'b11;
                    win_line_d  = 8'h00;
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (press_q) begin
                    board_d     = 18'h00000;
                    turn_d      = 1'b0;
                    winner_d    = 2'b00;
                    win_line_d  = 8'h00;
                    game_over_d = 1'b0;
                    state_d     = ST_PLAY;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // Game state and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_PLAY;
            board_q     <= 18'h00000;
            turn_q      <= 1'b0;
            change_q    <= 9'h000;
            illegal_q   <= 1'b0;
            winner_q    <= 2'b00;
            win_line_q  <= 8'h00;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            turn_q      <= turn_d;
            change_q    <= change_d;
            illegal_q   <= illegal_d;
            winner_q    <= winner_d;
            win_line_q  <= win_line_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.board     = board_q;
    assign bus.turn      = turn_q;
    assign bus.change    = change_q;
    assign bus.illegal   = illegal_q;
    assign bus.winner    = winner_q;
    assign bus.win_line  = win_line_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_move_ctrl.sv
// Self-checking bench for move_ctrl: a game-level reference model compared on
// every cycle, directed game scenarios with literal expectations, then random play.
`timescale 1ns/1ps
module tb_move_ctrl;
    localparam int DEB = 4;
    // Button sampled at edge 0, press accepted at edge DEB+2, move visible after edge DEB+3.
    localparam int LAT = DEB + 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    move_ctrl_if bus();

    move_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int chg_cnt  = 0;
    int ill_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    bit         m_started = 0;
    logic       m_b1 = 0, m_b2 = 0;
    logic [8:0] m_s1 = 0, m_s2 = 0;
    logic       m_stable = 0;
    int         m_run = 0;
    bit         m_pend1 = 0, m_pend2 = 0;
    int         m_cell [9];
    logic       m_turn = 0;
    logic [8:0] m_change = 0;
    logic       m_illegal = 0;
    logic [1:0] m_winner = 0;
    logic [7:0] m_winline = 0;
    logic       m_over = 0;
    bit         m_eval = 0;

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = 18'h0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic model_step();
        logic       syn_b;
        logic [8:0] syn_s;
        bit         press_now;
        bit         new_press;
        int         sel;
        logic [7:0] wl;
        int         mark;
        bit         full;
        if (rst == 1'b0) begin
            m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0;
            m_stable = 0; m_run = 0; m_pend1 = 0; m_pend2 = 0;
            foreach (m_cell[i]) m_cell[i] = 0;
            m_turn = 0; m_change = 0; m_illegal = 0;
            m_winner = 0; m_winline = 0; m_over = 0; m_eval = 0;
            m_started = 1;
            return;
        end
        syn_b = m_b2;
        syn_s = m_s2;
        press_now = m_pend2;
        m_change = 0;
        m_illegal = 0;
        if (m_eval) begin
            m_eval = 0; wl = 0; mark = 0; full = 1;
            for (int l = 0; l < 8; l++) begin
                if (m_cell[LINES[l][0]] != 0 && m_cell[LINES[l][0]] == m_cell[LINES[l][1]]
                    && m_cell[LINES[l][0]] == m_cell[LINES[l][2]]) begin
                    wl[l] = 1'b1;
                    mark = m_cell[LINES[l][0]];
                end
            end
            for (int c = 0; c < 9; c++) if (m_cell[c] == 0) full = 0;
            if (wl != 0) begin
                m_winner = 2'(mark); m_winline = wl; m_over = 1;
            end else if (full) begin
                m_winner = 2'b11; m_winline = 0; m_over = 1;
            end
        end else if (press_now) begin
            if (m_over) begin
                foreach (m_cell[i]) m_cell[i] = 0;
                m_turn = 0; m_winner = 0; m_winline = 0; m_over = 0;
            end else begin
                sel = -1;
                if ($countones(syn_s) == 1)
                    for (int i = 0; i < 9; i++) if (syn_s[i]) sel = i;
                if (sel >= 0 && m_cell[sel] == 0) begin
                    m_cell[sel] = m_turn ? 2 : 1;
                    m_change = syn_s;
                    m_turn = ~m_turn;
                    m_eval = 1;
                end else begin
                    m_illegal = 1;
                end
            end
        end
        // Accept the new button level once it has differed on DEB consecutive samples.
        new_press = 0;
        if (syn_b != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = syn_b;
                m_run = 0;
                new_press = syn_b;
            end
        end else begin
            m_run = 0;
        end
        m_pend2 = m_pend1;
        m_pend1 = new_press;
        m_b2 = m_b1; m_b1 = bus.button;
        m_s2 = m_s1; m_s1 = bus.switches;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_started) begin
            check("board",     32'(bus.board),     32'(m_board()));
            check("turn",      32'(bus.turn),      32'(m_turn));
            check("change",    32'(bus.change),    32'(m_change));
            check("illegal",   32'(bus.illegal),   32'(m_illegal));
            check("winner",    32'(bus.winner),    32'(m_winner));
            check("win_line",  32'(bus.win_line),  32'(m_winline));
            check("game_over", 32'(bus.game_over), 32'(m_over));
            if (bus.change != 9'h000) chg_cnt++;
            if (bus.illegal) ill_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_sw(input logic [8:0] sw);
        @(negedge clk);
        bus.switches = sw;
        bus.button = 1'b1;
        wait_n(12);
        bus.button = 1'b0;
        wait_n(12);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.button = 1'b0;
        wait_n(2);
        rst = 1'b1;
        wait_n(2);
    endtask

    task automatic timed_rise(output int lat);
        lat = 99;
        bus.button = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.change != 9'h000) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    int c0;
    int i0;
    int seen;
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int win_seq  [5] = '{0, 3, 1, 4, 2};
    int dbl_seq  [9] = '{1, 3, 2, 5, 4, 6, 8, 7, 0};

    initial begin
        bus.button = 1'b0;
        bus.switches = 9'h000;
        rst = 1'b0;
        wait_n(3);
        rst = 1'b1;
        check("reset_board", 32'(bus.board), 32'h0);
        check("reset_game_over", 32'(bus.game_over), 32'h0);

        // First move: X on square 0, timed from the rising edge.
        @(negedge clk);
        bus.switches = 9'h001;
        c0 = chg_cnt;
        timed_rise(lat);
        check("first_latency", 32'(lat), 32'(LAT));
        wait_n(6);
        bus.button = 1'b0;
        wait_n(12);
        check("first_board", 32'(bus.board), 32'h00001);
        check("first_turn", 32'(bus.turn), 32'h1);
        check("first_change_pulses", 32'(chg_cnt - c0), 32'h1);

        // Bounce: 3 high, 1 low, then steady high; one move, timed from the last rise.
        @(negedge clk);
        bus.switches = 9'h010;
        c0 = chg_cnt;
        bus.button = 1'b1;
        wait_n(3);
        bus.button = 1'b0;
        wait_n(1);
        timed_rise(lat);
        check("bounce_latency", 32'(lat), 32'(LAT));
        wait_n(6);
        bus.button = 1'b0;
        wait_n(12);
        check("bounce_pulses", 32'(chg_cnt - c0), 32'h1);
        check("bounce_board", 32'(bus.board), 32'h00201);
        check("bounce_turn", 32'(bus.turn), 32'h0);

        // Illegal: two switches up, then an occupied square.
        i0 = ill_cnt;
        press_sw(9'h003);
        check("illegal_multi", 32'(ill_cnt - i0), 32'h1);
        check("illegal_multi_board", 32'(bus.board), 32'h00201);
        press_sw(9'h001);
        check("illegal_occupied", 32'(ill_cnt - i0), 32'h2);
        check("illegal_turn", 32'(bus.turn), 32'h0);

        // X takes row 0.
        do_reset();
        foreach (win_seq[i]) press_sw(9'h001 << win_seq[i]);
        check("row_winner", 32'(bus.winner), 32'h1);
        check("row_win_line", 32'(bus.win_line), 32'h01);
        check("row_game_over", 32'(bus.game_over), 32'h1);
        press_sw(9'h000);
        check("restart_board", 32'(bus.board), 32'h0);
        check("restart_turn", 32'(bus.turn), 32'h0);
        check("restart_game_over", 32'(bus.game_over), 32'h0);

        // Draw.
        foreach (draw_seq[i]) press_sw(9'h001 << draw_seq[i]);
        check("draw_winner", 32'(bus.winner), 32'h3);
        check("draw_win_line", 32'(bus.win_line), 32'h00);
        press_sw(9'h000);

        // Last cell completes row 0 and the main diagonal together.
        foreach (dbl_seq[i]) press_sw(9'h001 << dbl_seq[i]);
        check("double_winner", 32'(bus.winner), 32'h1);
        check("double_win_line", 32'(bus.win_line), 32'h41);
        press_sw(9'h000);

        // Reset lands in the cycle the change strobe is high.
        @(negedge clk);
        bus.switches = 9'h010;
        bus.button = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.change != 9'h000) begin
                seen = 1;
                break;
            end
        end
        check("rst_change_seen", 32'(seen), 32'h1);
        rst = 1'b0;
        bus.button = 1'b0;
        @(negedge clk);
        check("rst_over_move_board", 32'(bus.board), 32'h0);
        check("rst_over_move_turn", 32'(bus.turn), 32'h0);
        rst = 1'b1;
        wait_n(12);
        press_sw(9'h001);
        check("rst_then_play", 32'(bus.board), 32'h00001);

        // Random play with bounces, bad selections and occasional resets.
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) bus.switches = 9'h001 << $urandom_range(0, 8);
            else bus.switches = 9'($urandom);
            bus.button = ~bus.button;
            wait_n($urandom_range(1, 14));
        end

        wait_n(20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
